mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store) of the pipelined MIPS core.
- Sequences each access against a fixed-latency memory and returns one-cycle acks.
- Provides combinational stall outputs to the hazard logic.
- Data port has priority; a starvation guard guarantees fetch progress.

Parameters:
- MEM_LATENCY, 2, cycles from mem_en high to mem_rdata valid (legal range 1..15).
- STARVE_LIMIT, 3, maximum consecutive DM grants while if_req is pending before IF is forced (1..15).

Ports:
- SYS_clk  in  1  system clock, rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch word address.
- if_flush  in  1  branch/exception redirect; cancels an in-flight fetch.
- if_ack  out  1  one-cycle fetch completion.
- if_rdata  out  32  fetched instruction; valid with if_ack.
- if_stall  out  1  if_req & ~if_ack.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  4  byte enables for a store.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle data completion.
- dm_rdata  out  32  load data with dm_ack; 0 for stores.
- dm_stall  out  1  dm_req & ~dm_ack.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  write enable; meaningful only with mem_en.
- mem_be  out  4  byte enables (4'b1111 for reads).
- mem_addr  out  32  access address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs except the stalls are registered.
- Reset: state IDLE. mem_en, mem_we, if_ack, dm_ack and busy are 0. mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata, starve_cnt and the cancel flag are all 0.
- Reset mid-operation aborts the access. The next cycle shows reset values, and no ack is issued for the aborted access.
- IDLE arbitration, in cycle t:
  - Grant IF if if_req && (!dm_req || starve_cnt == STARVE_LIMIT); otherwise grant DM if dm_req.
  - Latch owner, address, we, be and wdata. IF accesses use we=0 and be=4'b1111.
  - Next state is ISSUE.
- ISSUE (cycle t+1): mem_en=1 for exactly this cycle, with mem_* driven from the latched values. Load lat_cnt = MEM_LATENCY-1. Next state is WAIT.
- WAIT: decrement lat_cnt each cycle. When lat_cnt==0, mem_rdata is valid. Capture it into the owner's rdata register, raise the owner's ack, and go to RESP.
- Ack timing: the ack is high in cycle t+2+MEM_LATENCY.
- RESP: the ack is high for this single cycle. There is no arbitration here, since the requester still holds req this cycle. Next state is IDLE.
- Throughput: one access per MEM_LATENCY+3 cycles.
- Starvation counter (updated on each grant):
  - DM grant with if_req high: starve_cnt+1, saturating at STARVE_LIMIT.
  - IF grant, or DM grant with if_req low: starve_cnt=0.
- Flush:
  - if_flush high in any cycle of ISSUE or WAIT while the owner is IF sets the cancel flag.
  - A cancelled access still completes on memory, but if_ack stays 0 and if_rdata is unchanged.
  - The block then returns to IDLE via RESP.
  - if_flush has no effect when the owner is DM or the state is IDLE.
- Stores: dm_rdata=0 with dm_ack.
- Outside ISSUE, mem_en=0 and mem_we=0; mem_addr, mem_be and mem_wdata hold their last values.
- Requester rule: req must be deasserted, or a new request presented, in the cycle after ack. A req seen again in IDLE is treated as a new access.
- Address alignment is the requester's responsibility; the arbiter does not check it.

Decomposition:
- Package mips_mem_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE, WAIT, RESP);
  - the owner_t encoding (OWN_IF=0, OWN_DM=1);
  - READ_BE = 4'b1111;
  - the default latency and starvation constants.
- One sub-module, mem_arb_timer: loadable down-counter for lat_cnt, with a done flag.

Test Plan:
1. IF-only read, if_addr=0x00400000, mem_rdata=0x2008000A at the valid cycle -> mem_en at t+1 with mem_be=4'hF; if_ack and if_rdata=0x2008000A at t+4; dm_ack never asserts.
2. if_req and dm_req rise together (load from 0x10010000 returning 0x11223344) -> DM served first with dm_ack at t+4 and dm_rdata=0x11223344; IF mem_en at t+6; if_ack at t+9.
3. dm_req and if_req both held continuously for 12 accesses -> grant order DM,DM,DM,IF repeating; starve_cnt 1,2,3,0.
4. Store, dm_addr=0x10010004, dm_be=4'b0011, dm_wdata=0xDEADBEEF -> during the mem_en cycle mem_we=1, mem_be=0011, mem_addr and mem_wdata match the inputs; dm_ack with dm_rdata=0.
5. IF access with if_flush pulsed in the WAIT cycle -> no if_ack, if_rdata unchanged, busy=0 at t+5, next request is served normally.
6. SYS_reset asserted in the WAIT of a DM load -> next cycle all outputs are at reset values; no dm_ack; the next dm_req gets mem_en 1 cycle after it is sampled in IDLE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter of the pipelined MIPS core.
// Holds the arbiter state encoding, the port owner encoding and default timing constants.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } owner_t;

  localparam logic [3:0]  ReadBe             = 4'b1111;
  localparam int unsigned DefaultMemLatency  = 2;
  localparam int unsigned DefaultStarveLimit = 3;
  // Latency and starvation counters both cover the 1..15 range.
  localparam int unsigned CntWidth           = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter that tracks the remaining memory latency of an in-flight access.
// done is high while the count is zero; decrementing stops at zero.
module mem_arb_timer
  import mips_mem_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the data stage.
// Data has priority; a saturating starvation counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = DefaultMemLatency,
  parameter int unsigned STARVE_LIMIT = DefaultStarveLimit
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [CntWidth-1:0] LatLoad   = CntWidth'(MEM_LATENCY - 1);
  localparam logic [CntWidth-1:0] StarveMax = CntWidth'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic                cancel_q, cancel_d;
  logic [CntWidth-1:0] starve_q, starve_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;

  logic grant_if, grant_dm;
  logic timer_load, timer_dec, timer_done;
  logic flush_hit;

  assign grant_if  = if_req && (!dm_req || (starve_q == StarveMax));
  assign grant_dm  = dm_req && !grant_if;
  assign flush_hit = (owner_q == OwnIf) && if_flush;

  mem_arb_timer #(
    .Width (CntWidth)
  ) u_timer (
    .clk      (SYS_clk),
    .rst      (SYS_reset),
    .load     (timer_load),
    .load_val (LatLoad),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_if || grant_dm) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (timer_done) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    cancel_d    = cancel_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // mem_* registers double as the latched request, so ISSUE drives them directly.
        if (grant_if) begin
          owner_d    = OwnIf;
          we_d       = 1'b0;
          cancel_d   = 1'b0;
          starve_d   = '0;
          mem_en_d   = 1'b1;
          mem_be_d   = ReadBe;
          mem_addr_d = if_addr;
        end else if (grant_dm) begin
          owner_d     = OwnDm;
          we_d        = dm_we;
          cancel_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_be_d    = dm_we ? dm_be : ReadBe;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + CntWidth'(1);
          end
        end
      end
      StIssue: begin
        timer_load = 1'b1;
        if (flush_hit) cancel_d = 1'b1;
      end
      StWait: begin
        timer_dec = 1'b1;
        if (flush_hit) cancel_d = 1'b1;
        if (timer_done) begin
          if (owner_q == OwnDm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = we_q ? 32'h0 : mem_rdata;
          end else if (!(cancel_q || if_flush)) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      StResp: begin
        cancel_d = 1'b0;
      end
      default: begin
        cancel_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      owner_q     <= OwnIf;
      we_q        <= 1'b0;
      cancel_q    <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      cancel_q    <= cancel_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      assert (!(if_ack_q && dm_ack_q));
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_stall  = dm_req & ~dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single accesses plus hand-written
// sequences for contention, starvation, flush and mid-access reset.
module tb_mem_port_arbiter;

  localparam int unsigned Lat = 2;
  localparam int Win = 64;
  localparam int KEn = 0;
  localparam int KIfAck = 1;
  localparam int KDmAck = 2;

  logic        SYS_clk, SYS_reset;
  logic        if_req, if_flush, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack, dm_stall;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .MEM_LATENCY  (Lat),
    .STARVE_LIMIT (3)
  ) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .dm_stall  (dm_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  // Fixed-latency memory: data is valid only in the cycle Lat cycles after the mem_en cycle.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2008_000A;
      32'h1001_0000: return 32'h1122_3344;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  int          mem_cnt = 0;
  logic [31:0] mem_data = 32'h0;
  always @(posedge SYS_clk) begin
    if (mem_en) begin
      mem_cnt  <= Lat;
      mem_data <= mem_model(mem_addr);
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end
  assign mem_rdata = (mem_cnt == 1) ? mem_data : 32'hBAD0_BAD0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  logic        rec_en[Win], rec_we[Win], rec_busy[Win], rec_ifa[Win], rec_dma[Win];
  logic        rec_ifs[Win], rec_dms[Win];
  logic [3:0]  rec_be[Win];
  logic [31:0] rec_addr[Win], rec_wdata[Win], rec_ifd[Win], rec_dmd[Win];
  int          rec_n = 0;

  // Called at posedge+1; records n cycles at negedge, drops a request the cycle after its ack
  // unless hold is set, and optionally pulses if_flush / SYS_reset for one chosen cycle.
  task automatic run_window(input int n, input bit hold, input int flush_at,
                            input logic [31:0] flush_addr, input int reset_at);
    bit drop_if, drop_dm;
    drop_if = 1'b0;
    drop_dm = 1'b0;
    rec_n = n;
    for (int c = 0; c < n; c++) begin
      @(negedge SYS_clk);
      rec_en[c] = mem_en;     rec_we[c] = mem_we;       rec_be[c] = mem_be;
      rec_addr[c] = mem_addr; rec_wdata[c] = mem_wdata; rec_busy[c] = busy;
      rec_ifa[c] = if_ack;    rec_dma[c] = dm_ack;      rec_ifd[c] = if_rdata;
      rec_dmd[c] = dm_rdata;  rec_ifs[c] = if_stall;    rec_dms[c] = dm_stall;
      if (if_ack && !hold) drop_if = 1'b1;
      if (dm_ack && !hold) drop_dm = 1'b1;
      @(posedge SYS_clk);
      #1;
      if (drop_if) if_req = 1'b0;
      if (drop_dm) dm_req = 1'b0;
      if_flush = (c + 1 == flush_at);
      if (c + 1 == flush_at) if_addr = flush_addr;
      SYS_reset = (c + 1 == reset_at);
    end
  endtask

  function automatic logic pick(input int kind, input int c);
    case (kind)
      KEn:     return rec_en[c];
      KIfAck:  return rec_ifa[c];
      default: return rec_dma[c];
    endcase
  endfunction

  function automatic int first_hit(input int kind, input int from);
    for (int c = from; c < rec_n; c++) begin
      if (pick(kind, c) === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic int hit_count(input int kind);
    int k;
    k = 0;
    for (int c = 0; c < rec_n; c++) begin
      if (pick(kind, c) === 1'b1) k++;
    end
    return k;
  endfunction

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   ack_kind, other_kind, k;
    logic [31:0] exp_a;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0040_0000, 32'h0, 4'hF, 32'h2008_000A, "if_read"};
    vecs[1] = '{1'b1, 1'b0, 4'h4, 32'h1001_0000, 32'h0, 4'hF, 32'h1122_3344, "dm_load"};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h1001_0004, 32'hDEAD_BEEF, 4'h3, 32'h0, "dm_store"};
    vecs[3] = '{1'b1, 1'b1, 4'hF, 32'h1001_0008, 32'h0BAD_F00D, 4'hF, 32'h0, "dm_store_w"};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0040_0004, 32'h0, 4'hF, 32'h5A1A_5A5E, "if_read2"};

    SYS_reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (3) @(posedge SYS_clk);
    @(negedge SYS_clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;

    // Single accesses from the vector table.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      if (v.is_dm) begin
        dm_req = 1'b1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
        if_req = 1'b1; if_addr = v.addr;
      end
      run_window(8, 1'b0, -1, 32'h0, -1);
      ack_kind   = v.is_dm ? KDmAck : KIfAck;
      other_kind = v.is_dm ? KIfAck : KDmAck;
      check({v.name, "_en_cycle"}, 32'(first_hit(KEn, 0)), 32'd1);
      check({v.name, "_en_count"}, 32'(hit_count(KEn)), 32'd1);
      check({v.name, "_addr"}, rec_addr[1], v.addr);
      check({v.name, "_be"}, 32'(rec_be[1]), 32'(v.exp_be));
      check({v.name, "_we"}, 32'(rec_we[1]), 32'(v.is_dm && v.we));
      if (v.we) check({v.name, "_wdata"}, rec_wdata[1], v.wdata);
      check({v.name, "_we_after"}, 32'(rec_we[2]), 32'd0);
      check({v.name, "_ack_cycle"}, 32'(first_hit(ack_kind, 0)), 32'd4);
      check({v.name, "_ack_count"}, 32'(hit_count(ack_kind)), 32'd1);
      check({v.name, "_other_ack"}, 32'(hit_count(other_kind)), 32'd0);
      check({v.name, "_rdata"}, v.is_dm ? rec_dmd[4] : rec_ifd[4], v.exp_rdata);
      check({v.name, "_stall_c0"}, 32'(v.is_dm ? rec_dms[0] : rec_ifs[0]), 32'd1);
      check({v.name, "_stall_ack"}, 32'(v.is_dm ? rec_dms[4] : rec_ifs[4]), 32'd0);
      check({v.name, "_busy"}, 32'({rec_busy[1], rec_busy[5]}), 32'b10);
    end

    // Simultaneous requests: data first, then fetch.
    if_req = 1'b1; if_addr = 32'h0040_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h1001_0000;
    run_window(12, 1'b0, -1, 32'h0, -1);
    check("both_dm_en_addr", rec_addr[1], 32'h1001_0000);
    check("both_dm_ack", 32'(first_hit(KDmAck, 0)), 32'd4);
    check("both_dm_rdata", rec_dmd[4], 32'h1122_3344);
    check("both_if_stall", 32'(rec_ifs[4]), 32'd1);
    check("both_if_en", 32'(first_hit(KEn, 2)), 32'd6);
    check("both_if_en_addr", rec_addr[6], 32'h0040_0008);
    check("both_if_ack", 32'(first_hit(KIfAck, 0)), 32'd9);
    check("both_if_rdata", rec_ifd[9], 32'h5A1A_5A52);

    // Continuous contention: DM,DM,DM,IF repeating.
    if_req = 1'b1; if_addr = 32'h0040_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0020;
    run_window(60, 1'b1, -1, 32'h0, -1);
    if_req = 1'b0;
    dm_req = 1'b0;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      if (rec_en[c] === 1'b1) begin
        exp_a = (k % 4 == 3) ? 32'h0040_0010 : 32'h1001_0020;
        check($sformatf("starve_addr_%0d", k), rec_addr[c], exp_a);
        check($sformatf("starve_cyc_%0d", k), 32'(c), 32'(1 + 5 * k));
        k++;
      end
    end
    check("starve_grants", 32'(k), 32'd12);
    @(posedge SYS_clk);
    #1;

    // Fetch flushed in WAIT; redirected fetch follows.
    if_req = 1'b1; if_addr = 32'h0040_0020;
    run_window(12, 1'b0, 2, 32'h0040_0100, -1);
    check("flush_en_addr", rec_addr[1], 32'h0040_0020);
    check("flush_ack_count", 32'(hit_count(KIfAck)), 32'd1);
    check("flush_ack_cycle", 32'(first_hit(KIfAck, 0)), 32'd9);
    check("flush_rdata_keep4", rec_ifd[4], 32'h5A1A_5A4A);
    check("flush_rdata_keep5", rec_ifd[5], 32'h5A1A_5A4A);
    check("flush_stall", 32'(rec_ifs[4]), 32'd1);
    check("flush_busy5", 32'(rec_busy[5]), 32'd0);
    check("flush_next_en", 32'(first_hit(KEn, 2)), 32'd6);
    check("flush_next_addr", rec_addr[6], 32'h0040_0100);
    check("flush_next_rdata", rec_ifd[9], 32'h5A1A_5B5A);

    // Reset during WAIT of a data load.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0010;
    run_window(10, 1'b0, -1, 32'h0, 2);
    check("rstmid_busy", 32'(rec_busy[3]), 32'd0);
    check("rstmid_en", 32'({rec_en[3], rec_we[3]}), 32'd0);
    check("rstmid_addr", rec_addr[3], 32'h0);
    check("rstmid_be", 32'(rec_be[3]), 32'd0);
    check("rstmid_dm_rdata", rec_dmd[3], 32'h0);
    check("rstmid_if_rdata", rec_ifd[3], 32'h0);
    check("rstmid_ack_count", 32'(hit_count(KDmAck)), 32'd1);
    check("rstmid_next_en", 32'(first_hit(KEn, 2)), 32'd4);
    check("rstmid_ack_cycle", 32'(first_hit(KDmAck, 0)), 32'd7);
    check("rstmid_rdata", rec_dmd[7], 32'h4A5B_5A4A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
